// File: rtl/alu_issue_ctrl.sv
// Issues register-based instructions to an external combinational ALU and retires results into an 8x8 register file.
// Latency: accept to done = 2 edges. A new instruction is accepted at most every second cycle.
// Backpressure: in_ready is low during EXEC and during reset, and in_valid is ignored then.
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [$clog2(NREG)-1:0] in_rs,
    input  logic [$clog2(NREG)-1:0] in_rt,
    input  logic [DW-1:0]           in_imm,
    output logic [3:0]              alu_ctrl,
    output logic [DW-1:0]           alu_x,
    output logic [DW-1:0]           alu_y,
    input  logic [DW-1:0]           alu_out,
    input  logic                    alu_carry,
    output logic                    done,
    output logic                    err,
    output logic [DW-1:0]           res_data,
    output logic                    carry_flag,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]           dbg_data
);
    localparam int AW = $clog2(NREG);
    localparam logic [3:0] OP_LOADI = 4'b1111;
    localparam logic [3:0] OP_RSV0  = 4'b1101;
    localparam logic [3:0] OP_RSV1  = 4'b1110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ready_en;
    logic            accept;
    logic [3:0]      op_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   imm_q;
    logic [DW-1:0]   regs [NREG];

    // ready_en keeps in_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = ready_en && (state == IDLE);
    end

    assign accept   = in_valid && in_ready;
    assign dbg_data = regs[dbg_addr];

    // r0 is never written, so it reads 0 on both operand and debug ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_ctrl   <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            res_data   <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                op_q     <= in_op;
                rd_q     <= in_rd;
                imm_q    <= in_imm;
                alu_ctrl <= in_op;
                alu_x    <= regs[in_rs];
                alu_y    <= regs[in_rt];
            end
            if (state == EXEC) begin
                done <= 1'b1;
                if (op_q == OP_RSV0 || op_q == OP_RSV1) begin
                    err      <= 1'b1;
                    res_data <= '0;
                end else if (op_q == OP_LOADI) begin
                    res_data <= imm_q;
                    if (rd_q != '0) regs[rd_q] <= imm_q;
                end else begin
                    res_data   <= alu_out;
                    carry_flag <= alu_carry;
                    if (rd_q != '0) regs[rd_q] <= alu_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and random instruction streams against a register-file reference model, with a behavioural ALU attached.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd, in_rs, in_rt;
    logic [7:0] in_imm;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic       alu_carry;
    logic       done, err;
    logic [7:0] res_data;
    logic       carry_flag;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_regs [8];
    logic       m_carry;

    alu_issue_ctrl #(.NREG(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .done(done), .err(err), .res_data(res_data), .carry_flag(carry_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'd0:    return {1'b0, x} + {1'b0, y};
            4'd1:    return {1'b0, x} - {1'b0, y};
            4'd2:    return {1'b0, x & y};
            4'd3:    return {1'b0, x | y};
            4'd4:    return {1'b0, ~x};
            4'd5:    return {1'b0, x ^ y};
            4'd6:    return {1'b0, ~(x | y)};
            4'd7:    return {x[7], x[6:0], 1'b0};
            4'd8:    return {x[0], 1'b0, x[7:1]};
            4'd9:    return {x[0], x[7], x[7:1]};
            4'd10:   return {x[7], x[6:0], x[7]};
            4'd11:   return {x[0], x[0], x[7:1]};
            4'd12:   return {8'h00, x == y};
            default: return 9'h000;
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        dbg_addr = a;
        #1 chk(tag, dbg_data, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input bit hold,
                         output int waited);
        logic [7:0] ex, ey, eres;
        logic       eerr;
        logic [8:0] r;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
        dbg_addr = rd;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        ex = m_regs[rs];
        ey = m_regs[rt];
        eerr = (op == 4'b1101 || op == 4'b1110);
        if (eerr) eres = 8'h00;
        else if (op == 4'b1111) eres = imm;
        else begin
            r = alu_fn(op, ex, ey);
            eres = r[7:0];
            m_carry = r[8];
        end
        if (!eerr && rd != 3'd0) m_regs[rd] = eres;

        @(posedge clk); #1;
        chk("alu_ctrl", alu_ctrl, op);
        chk("alu_x", alu_x, ex);
        chk("alu_y", alu_y, ey);
        chk("exec_ready", in_ready, 0);
        chk("exec_done", done, 0);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        chk("exec_ready_mid", in_ready, 0);
        @(posedge clk); #1;
        chk("done", done, 1);
        chk("err", err, eerr);
        chk("res_data", res_data, eres);
        chk("carry_flag", carry_flag, m_carry);
        chk("dbg_rd", dbg_data, m_regs[rd]);
        chk("ready_after", in_ready, 1);
        if (!hold) begin
            @(posedge clk); #1;
            chk("done_pulse_end", done, 0);
            chk("err_pulse_end", err, 0);
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        in_imm = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_carry = 1'b0;
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {alu_ctrl, alu_x, alu_y, res_data, carry_flag, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_at_release", in_ready, 0);
        @(posedge clk); #1 chk("ready_after_release", in_ready, 1);

        // 1-2: loads and a dependent add
        issue(4'hF, 3'd1, 3'd0, 3'd0, 8'h7F, 0, w);
        issue(4'hF, 3'd2, 3'd0, 3'd0, 8'h01, 0, w);
        peek(3'd1, 8'h7F, "r1_7f");
        peek(3'd2, 8'h01, "r2_01");
        chk("carry_after_loadi", carry_flag, 0);
        issue(4'h0, 3'd3, 3'd1, 3'd2, 8'h00, 0, w);
        peek(3'd3, 8'h80, "r3_80");

        // 3: carry set by ADD, kept by LOADI, cleared by AND
        issue(4'hF, 3'd4, 3'd0, 3'd0, 8'hFF, 0, w);
        issue(4'h0, 3'd5, 3'd4, 3'd2, 8'h00, 0, w);
        chk("carry_set", carry_flag, 1);
        peek(3'd5, 8'h00, "r5_00");
        issue(4'hF, 3'd6, 3'd0, 3'd0, 8'hA5, 0, w);
        chk("carry_kept", carry_flag, 1);
        issue(4'h2, 3'd7, 3'd1, 3'd2, 8'h00, 0, w);
        chk("carry_cleared", carry_flag, 0);

        // 4: back-to-back with in_valid held, dependency through r1
        issue(4'hF, 3'd1, 3'd0, 3'd0, 8'h10, 1, w);
        issue(4'h0, 3'd3, 3'd1, 3'd1, 8'h00, 1, w);
        chk("b2b_wait1", w, 0);
        issue(4'h1, 3'd5, 3'd3, 3'd2, 8'h00, 0, w);
        chk("b2b_wait2", w, 0);
        peek(3'd5, 8'h1F, "b2b_dep");

        // 5: r0 discard and reserved opcode
        issue(4'hF, 3'd0, 3'd0, 3'd0, 8'h55, 0, w);
        peek(3'd0, 8'h00, "r0_zero");
        issue(4'hD, 3'd6, 3'd1, 3'd2, 8'h00, 0, w);
        peek(3'd6, 8'hA5, "r6_unchanged");

        // 6: reset during EXEC drops the instruction
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'h0; in_rd = 3'd7; in_rs = 3'd1; in_rt = 3'd2; dbg_addr = 3'd7;
        @(posedge clk); #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_exec_outs", {alu_ctrl, alu_x, alu_y, res_data, carry_flag, err, done}, 0);
        chk("rst_exec_ready", in_ready, 0);
        chk("rst_exec_r7", dbg_data, 0);
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_ready_low", in_ready, 0);
        @(posedge clk); #1;
        chk("rel_ready_high", in_ready, 1);
        chk("rel_no_done", done, 0);

        // random stream against the model
        for (int n = 0; n < 60; n++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), w);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int a = 0; a < 8; a++) peek(3'(a), m_regs[a], "final_reg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
